clock_monitor: RTL and testbench

- Receiving-end checker for the three divided clocks clk1/clk2/clk3 produced by the clock divider.
- Samples each divided clock in the master clock domain and measures every half-period in master-clock cycles.
- Reports per-channel locked / fault / stopped status, plus a combined fault interrupt, to the system controller.

---
 rtl/clock_monitor_pkg.sv | 33 +++
 rtl/clock_monitor_if.sv | 27 ++
 rtl/clock_monitor_channel.sv | 136 +++++++++++++
 rtl/clock_monitor.sv | 54 +++++
 tb/tb_clock_monitor.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types and default constants for the divided-clock monitor.
// Revision: 1.0
`default_nettype none

package clock_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_TRACK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4,
    ST_STOPPED = 3'd5
  } state_t;

  localparam int DEF_EXP_HALF1  = 8;
  localparam int DEF_EXP_HALF2  = 4;
  localparam int DEF_EXP_HALF3  = 2;
  localparam int DEF_TOL        = 0;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_TIMEOUT    = 32;
  localparam int DEF_CNT_W      = 6;

  // The counter must hold TIMEOUT, and a nominal period must be distinguishable from a timeout.
  function automatic bit cnt_w_ok(input int cnt_w, input int timeout, input int exp_half,
                                  input int tol, input int lock_count);
    return (timeout < (1 << cnt_w)) && (exp_half + tol < timeout) &&
           (lock_count > 0) && (lock_count < (1 << cnt_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_monitor_if.sv
// Bus between the system controller and the clock monitor.
// Revision: 1.0
`default_nettype none

interface clock_monitor_if;
  logic       clk1;
  logic       clk2;
  logic       clk3;
  logic [2:0] chk_en;
  logic       clear_faults;
  logic [2:0] locked;
  logic [2:0] fault;
  logic [2:0] stopped;
  logic       fault_irq;

  modport master (
    output clk1, clk2, clk3, chk_en, clear_faults,
    input  locked, fault, stopped, fault_irq
  );

  modport slave (
    input  clk1, clk2, clk3, chk_en, clear_faults,
    output locked, fault, stopped, fault_irq
  );
endinterface

`default_nettype wire

// File: rtl/clock_monitor_channel.sv
// One monitored clock: edge sampler, half-period counter, lock counter and status FSM.
// Revision: 1.0
`default_nettype none

module clock_monitor_channel
  import clock_monitor_pkg::*;
#(
  parameter int EXP_HALF   = DEF_EXP_HALF1,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic en,
  input  logic clear_faults,
  output logic locked,
  output logic fault,
  output logic stopped
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_V    = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W:0]   EXP_V     = (CNT_W + 1)'(EXP_HALF);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);

  if (!cnt_w_ok(CNT_W, TIMEOUT, EXP_HALF, TOL, LOCK_COUNT)) begin : g_param_check
    $error("clock_monitor_channel: CNT_W too narrow for TIMEOUT/EXP_HALF/TOL/LOCK_COUNT");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] hcnt, hcnt_next;
  logic [CNT_W-1:0] good_cnt, good_next;
  logic             in_q, in_d;
  logic             edge_det, timeout, match;
  logic [CNT_W:0]   meas, diff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q     <= 1'b0;
      in_d     <= 1'b0;
      state    <= ST_IDLE;
      hcnt     <= '0;
      good_cnt <= '0;
    end else begin
      in_q     <= clk_in;
      in_d     <= in_q;
      state    <= state_next;
      hcnt     <= hcnt_next;
      good_cnt <= good_next;
    end
  end

  // hcnt saturates at TIMEOUT, so meas never wraps in the extra-bit compare.
  assign edge_det = in_q ^ in_d;
  assign timeout  = (hcnt == TIMEOUT_V);
  assign meas     = {1'b0, hcnt} + (CNT_W + 1)'(1);
  assign diff     = (meas >= EXP_V) ? (meas - EXP_V) : (EXP_V - meas);
  assign match    = (diff <= TOL_V);

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    if (edge_det)     hcnt_next = '0;
    else if (timeout) hcnt_next = hcnt;
    else              hcnt_next = hcnt + ONE;

    if (!en) begin
      state_next = ST_IDLE;
      hcnt_next  = '0;
      good_next  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_SYNC;
          hcnt_next  = '0;
          good_next  = '0;
        end
        ST_SYNC: begin
          if (edge_det) begin
            state_next = ST_TRACK;
            good_next  = '0;
          end else if (timeout) begin
            state_next = ST_STOPPED;
          end
        end
        ST_TRACK: begin
          if (edge_det) begin
            if (match) begin
              good_next = good_cnt + ONE;
              if (good_cnt + ONE == LOCK_V) state_next = ST_LOCKED;
            end else begin
              state_next = ST_FAULT;
            end
          end else if (timeout) begin
            state_next = ST_STOPPED;
          end
        end
        ST_LOCKED: begin
          if (edge_det) begin
            if (!match) state_next = ST_FAULT;
          end else if (timeout) begin
            state_next = ST_STOPPED;
          end
        end
        ST_FAULT: begin
          if (clear_faults) begin
            state_next = ST_SYNC;
            hcnt_next  = '0;
          end
        end
        ST_STOPPED: begin
          // A clear outranks a coincident edge, which is then dropped.
          if (clear_faults) begin
            state_next = ST_SYNC;
            hcnt_next  = '0;
          end else if (edge_det) begin
            state_next = ST_TRACK;
            good_next  = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign locked  = (state == ST_LOCKED);
  assign fault   = (state == ST_FAULT);
  assign stopped = (state == ST_STOPPED);

endmodule

`default_nettype wire

// File: rtl/clock_monitor.sv
// Three independent divided-clock checkers plus the combined fault interrupt.
// Revision: 1.0
`default_nettype none

module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int EXP_HALF1  = DEF_EXP_HALF1,
  parameter int EXP_HALF2  = DEF_EXP_HALF2,
  parameter int EXP_HALF3  = DEF_EXP_HALF3,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic            clock,
  input  logic            reset,
  clock_monitor_if.slave  bus
);

  localparam int EXP_TABLE [3] = '{EXP_HALF1, EXP_HALF2, EXP_HALF3};

  logic [2:0] clk_vec;
  logic [2:0] locked_v, fault_v, stopped_v;

  assign clk_vec = {bus.clk3, bus.clk2, bus.clk1};

  for (genvar i = 0; i < 3; i++) begin : g_chan
    clock_monitor_channel #(
      .EXP_HALF   (EXP_TABLE[i]),
      .TOL        (TOL),
      .LOCK_COUNT (LOCK_COUNT),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .clk_in       (clk_vec[i]),
      .en           (bus.chk_en[i]),
      .clear_faults (bus.clear_faults),
      .locked       (locked_v[i]),
      .fault        (fault_v[i]),
      .stopped      (stopped_v[i])
    );
  end

  assign bus.locked    = locked_v;
  assign bus.fault     = fault_v;
  assign bus.stopped   = stopped_v;
  assign bus.fault_irq = (|fault_v) | (|stopped_v);

endmodule

`default_nettype wire

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (TOL=0 and TOL=1) fed identical stimulus, checked against a half-period model.
// Revision: 1.0
`default_nettype none

module tb_clock_monitor;

  localparam int TIMEOUT    = 32;
  localparam int LOCK_COUNT = 4;
  localparam int EXP  [3] = '{8, 4, 2};
  localparam int TOLS [2] = '{0, 1};
  localparam int M_IDLE = 0, M_SYNC = 1, M_TRACK = 2, M_LOCKED = 3, M_FAULT = 4, M_STOPPED = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] clkv  = 3'b000;
  logic [2:0] en    = 3'b000;
  logic       clr   = 1'b0;

  always #5 clock = ~clock;

  clock_monitor_if bus0 ();
  clock_monitor_if bus1 ();

  assign bus0.clk1 = clkv[0];  assign bus1.clk1 = clkv[0];
  assign bus0.clk2 = clkv[1];  assign bus1.clk2 = clkv[1];
  assign bus0.clk3 = clkv[2];  assign bus1.clk3 = clkv[2];
  assign bus0.chk_en = en;     assign bus1.chk_en = en;
  assign bus0.clear_faults = clr;
  assign bus1.clear_faults = clr;

  clock_monitor dut0 (.clock(clock), .reset(reset), .bus(bus0));
  clock_monitor #(.TOL(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  // Model: per channel status plus the cycle at which the half-period measurement last restarted.
  int st [2][3];
  int good [2][3];
  int lref [2][3];
  bit h1 [3];
  bit h2 [3];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  bit gen_on [3];
  int cnt [3];
  int cur [3];
  int hq [3][$];
  bit jitter = 1'b0;

  function automatic logic [9:0] got_vec(input int d);
    if (d == 0) return {bus0.fault_irq, bus0.stopped, bus0.fault, bus0.locked};
    return {bus1.fault_irq, bus1.stopped, bus1.fault, bus1.locked};
  endfunction

  function automatic logic [9:0] exp_vec(input int d);
    logic [2:0] l, f, s;
    for (int ch = 0; ch < 3; ch++) begin
      l[ch] = (st[d][ch] == M_LOCKED);
      f[ch] = (st[d][ch] == M_FAULT);
      s[ch] = (st[d][ch] == M_STOPPED);
    end
    return {(|f) | (|s), s, f, l};
  endfunction

  function automatic int next_half(input int ch);
    int h;
    if (hq[ch].size() > 0) return hq[ch].pop_front();
    h = EXP[ch];
    if (jitter && $urandom_range(0, 3) == 0) h = h + int'($urandom_range(0, 4)) - 2;
    if (h < 1) h = 1;
    return h;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 3; ch++) begin
        st[d][ch] = M_IDLE; good[d][ch] = 0; lref[d][ch] = cyc - 1;
      end
    for (int ch = 0; ch < 3; ch++) begin h1[ch] = 1'b0; h2[ch] = 1'b0; end
  endtask

  task automatic model_ch(input int d, input int ch, input bit ed);
    int hc, meas, dev;
    bit m;
    hc = cyc - lref[d][ch] - 1;
    if (hc > TIMEOUT) hc = TIMEOUT;
    meas = hc + 1;
    dev  = meas - EXP[ch];
    if (dev < 0) dev = -dev;
    m = (dev <= TOLS[d]);
    if (!en[ch]) begin
      st[d][ch] = M_IDLE; good[d][ch] = 0; lref[d][ch] = cyc;
    end else if (st[d][ch] == M_IDLE) begin
      st[d][ch] = M_SYNC; good[d][ch] = 0; lref[d][ch] = cyc;
    end else if (clr && (st[d][ch] == M_FAULT || st[d][ch] == M_STOPPED)) begin
      st[d][ch] = M_SYNC; lref[d][ch] = cyc;
    end else if (ed) begin
      lref[d][ch] = cyc;
      case (st[d][ch])
        M_SYNC, M_STOPPED: begin st[d][ch] = M_TRACK; good[d][ch] = 0; end
        M_TRACK: begin
          if (m) begin
            good[d][ch]++;
            if (good[d][ch] == LOCK_COUNT) st[d][ch] = M_LOCKED;
          end else st[d][ch] = M_FAULT;
        end
        M_LOCKED: if (!m) st[d][ch] = M_FAULT;
        default: ;
      endcase
    end else if (hc == TIMEOUT &&
                 (st[d][ch] == M_SYNC || st[d][ch] == M_TRACK || st[d][ch] == M_LOCKED)) begin
      st[d][ch] = M_STOPPED;
    end
  endtask

  // Drive one master cycle (called at a falling edge), advance the model, move to the next falling edge.
  task automatic step();
    for (int ch = 0; ch < 3; ch++) begin
      if (gen_on[ch]) begin
        cnt[ch]++;
        if (cnt[ch] >= cur[ch]) begin
          clkv[ch] = ~clkv[ch];
          cnt[ch]  = 0;
          cur[ch]  = next_half(ch);
        end
      end
    end
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 3; ch++) model_ch(d, ch, h1[ch] ^ h2[ch]);
    for (int ch = 0; ch < 3; ch++) begin h2[ch] = h1[ch]; h1[ch] = clkv[ch]; end
    cyc++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (got_vec(d) !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got=%b exp=%b", d, got_vec(d), 10'd0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL idle dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_lock();
    int edges = 0;
    bit seen = 1'b0;
    en = 3'b001; gen_on[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0 && (h1[0] ^ h2[0])) edges++;
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL lock dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
      if (!seen && bus0.locked[0] === 1'b1) begin
        seen = 1'b1;
        n_tests++;
        if (edges != 5) begin
          n_fail++;
          $display("FAIL lock_edge_count got=%0d exp=%0d", edges, 5);
        end
      end
    end
    n_tests++;
    if ({bus0.locked[0], bus0.fault[0], bus0.stopped[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL lock_final got=%b exp=100", {bus0.locked[0], bus0.fault[0], bus0.stopped[0]});
    end
  endtask

  task automatic test_mismatch();
    hq[0].push_back(7);
    for (int i = 0; i < 54; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL mismatch dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
    n_tests++;
    if ({bus0.fault[0], bus0.locked[0], bus0.fault_irq, bus1.locked[0]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL mismatch_sticky got=%b exp=1011",
               {bus0.fault[0], bus0.locked[0], bus0.fault_irq, bus1.locked[0]});
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL relock dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
    n_tests++;
    if (bus0.locked[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL relock_final got=%b exp=1", bus0.locked[0]);
    end
  endtask

  task automatic test_stop();
    en = 3'b011; gen_on[1] = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i == 40) gen_on[1] = 1'b0;
      if (i == 85) begin gen_on[1] = 1'b1; cnt[1] = 0; end
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL stop dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
      if (i == 84) begin
        n_tests++;
        if ({bus0.stopped[1], bus1.stopped[1], bus0.fault_irq} !== 3'b111) begin
          n_fail++;
          $display("FAIL stop_flag got=%b exp=111", {bus0.stopped[1], bus1.stopped[1], bus0.fault_irq});
        end
      end
    end
    n_tests++;
    if ({bus0.locked[1], bus0.stopped[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL stop_relock got=%b exp=10", {bus0.locked[1], bus0.stopped[1]});
    end
  endtask

  task automatic test_priority();
    bit done = 1'b0;
    hq[0].push_back(6);
    for (int i = 0; i < 120; i++) begin
      if (!done && st[0][0] == M_FAULT && (h1[0] ^ h2[0])) begin
        clr  = 1'b1;
        done = 1'b1;
      end
      step();
      clr = 1'b0;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL priority dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
    n_tests++;
    if (!done || bus0.locked[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL priority_clear_edge got=%b exp=1 (clear issued=%0d)", bus0.locked[0], done);
    end
    en = 3'b111; gen_on[2] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL en_lock dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
    en[2] = 1'b0;
    step();
    n_tests++;
    if ({bus0.locked[2], bus0.fault[2], bus0.stopped[2], bus1.locked[2]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_drop got=%b exp=0000",
               {bus0.locked[2], bus0.fault[2], bus0.stopped[2], bus1.locked[2]});
    end
  endtask

  task automatic test_async_reset();
    en = 3'b111;
    for (int i = 0; i < 14; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL pre_reset dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (got_vec(d) !== 10'd0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got=%b exp=%b", d, got_vec(d), 10'd0);
      end
    end
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 80; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL post_reset dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
    n_tests++;
    if ({bus0.locked, bus1.locked} !== 6'b111111) begin
      n_fail++;
      $display("FAIL reset_relock got=%b exp=111111", {bus0.locked, bus1.locked});
    end
  endtask

  task automatic test_tolerance();
    en = 3'b000;
    step();
    for (int i = 0; i < 20; i++) begin hq[2].push_back(2); hq[2].push_back(3); end
    en = 3'b100;
    for (int i = 0; i < 45; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL tolerance dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
    n_tests++;
    if ({bus1.locked[2], bus1.fault[2], bus0.fault[2]} !== 3'b101) begin
      n_fail++;
      $display("FAIL tolerance_final got=%b exp=101", {bus1.locked[2], bus1.fault[2], bus0.fault[2]});
    end
  endtask

  task automatic test_random();
    jitter = 1'b1;
    en = 3'b111;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) en[$urandom_range(0, 2)] ^= 1'b1;
      clr = ($urandom_range(0, 49) == 0);
      for (int ch = 0; ch < 3; ch++) begin
        if (gen_on[ch] && $urandom_range(0, 299) == 0) gen_on[ch] = 1'b0;
        else if (!gen_on[ch] && $urandom_range(0, 39) == 0) begin gen_on[ch] = 1'b1; cnt[ch] = 0; end
      end
      step();
      clr = 1'b0;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc=%0d got=%b exp=%b", d, cyc, got_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  initial begin
    for (int ch = 0; ch < 3; ch++) begin
      gen_on[ch] = 1'b0; cnt[ch] = 0; cur[ch] = EXP[ch];
    end
    model_reset();
    test_reset();
    test_lock();
    test_mismatch();
    test_stop();
    test_priority();
    test_async_reset();
    test_tolerance();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
